alu_mul_sequencer: RTL
======================

// Module: alu_mul_sequencer
// PURPOSE
//   Multi-cycle controller that computes the low DATA_WIDTH bits of op_a*op_b by shift-and-add.
//   It reuses the shared combinational ALU: ADD accumulates, SLL doubles the multiplicand.
//   Sits between the core datapath and the ALU. While idle, the core drives the ALU directly.
//   While the sequencer runs, it owns the ALU and asserts busy so the core stalls.
// PARAMETERS
//   DATA_WIDTH     32       operand/result width
//   OPCODE_LENGTH  4        ALU Operation width
//   OP_ADD         4'b0010  ALU code for ADD
//   OP_SLL         4'b0100  ALU code for shift-left
// PORTS
//   clk         in   1              single clock, rising edge
//   reset_n     in   1              asynchronous, active-low reset
//   start       in   1              request a multiply; accepted only in IDLE
//   op_a        in   DATA_WIDTH     multiplicand, sampled on an accepted start
//   op_b        in   DATA_WIDTH     multiplier, sampled on an accepted start
//   busy        out  1              1 in ADD/SHIFT; core stall
//   done        out  1              1-cycle pulse in DONE
//   result      out  DATA_WIDTH     registered product, mod 2^DATA_WIDTH
//   core_srca   in   DATA_WIDTH     core's ALU SrcA
//   core_srcb   in   DATA_WIDTH     core's ALU SrcB
//   core_op     in   OPCODE_LENGTH  core's ALU Operation
//   alu_srca    out  DATA_WIDTH     to ALU SrcA
//   alu_srcb    out  DATA_WIDTH     to ALU SrcB
//   alu_op      out  OPCODE_LENGTH  to ALU Operation
//   alu_result  in   DATA_WIDTH     from ALU ALUResult
// BEHAVIOUR
//   Reset (async, reset_n=0): state=IDLE; acc, mcand, mplier, result = 0; busy=0, done=0.
//   Reset mid-operation aborts the operation: no done pulse, result cleared to 0.
//   ALU mux (combinational):
//     - IDLE/DONE: alu_* = core_*.
//     - ADD: {acc, mcand, OP_ADD}.
//     - SHIFT: {mcand, 1, OP_SLL}.
//   FSM states: IDLE, ADD, SHIFT, DONE.
//   IDLE, start=1:
//     - Latch mcand<=op_a, mplier<=op_b, acc<=0.
//     - Next state: op_b==0 -> DONE; op_b[0] -> ADD; else SHIFT.
//   IDLE, start=0: stay in IDLE.
//   ADD: acc<=alu_result; next SHIFT.
//   SHIFT:
//     - mcand<=alu_result; mplier<=mplier>>1 (logical, local, no ALU).
//     - Next state: (mplier>>1)==0 -> DONE; mplier[1] -> ADD; else SHIFT.
//   DONE: result<=acc; done=1; busy=0; next IDLE.
//     - start is ignored in DONE and in ADD/SHIFT; no queuing.
//   result holds its value until the next DONE or reset. It is valid from the cycle after DONE.
//   Arithmetic:
//     - Wraps mod 2^DATA_WIDTH.
//     - Signed and unsigned low products are identical, so there is no sign handling.
//   Latency: start edge -> done cycle = popcount(op_b) + (msb_index(op_b)+1) + 1 cycles.
//     - op_b==0 gives 1 cycle.
//     - Max 2*DATA_WIDTH+1 cycles.
//   op_a/op_b may change after start is accepted without effect.
//   core_* changes during busy do not reach the ALU.
// TESTING
//   T1: op_a=3, op_b=5, start
//       -> states ADD,SHIFT,SHIFT,ADD,SHIFT,DONE; done in 6th cycle; result=15.
//   T2: op_a=0x1234, op_b=0, start -> DONE next cycle, busy never 1, result=0.
//   T3: op_a=op_b=0xFFFFFFFF -> busy for 64 cycles, done on the 65th, result=0x00000001.
//   T4: op_a=0xFFFFFFF9 (-7), op_b=6 -> result=0xFFFFFFD6 (-42).
//   T5: op_a=9, op_b=0x80, start; reset_n=0 at the 4th busy cycle
//       -> IDLE at once, busy=0, no done, result=0.
//       Then a new start with 2*3 -> result=6.
//   T6: core_op=OP_ADD, core_srca=2, core_srcb=3 while IDLE -> alu_* mirror core.
//       Start 2*2 -> alu_op driven by the FSM.
//       A start pulse mid-run is ignored; result=4.

Source files
------------

// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: shift-and-add multiplier that borrows the shared ALU.
// Ports:
//   clk, reset_n             clock, async active-low reset
//   start, op_a, op_b        multiply request and operands
//   busy, done, result       core stall, 1-cycle completion pulse, product
//   core_srca/srcb/op        core's ALU request, forwarded while idle
//   alu_srca/srcb/op         to the shared ALU
//   alu_result               from the shared ALU
module alu_mul_sequencer #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter logic [OPCODE_LENGTH-1:0] OP_ADD = 4'b0010,
    parameter logic [OPCODE_LENGTH-1:0] OP_SLL = 4'b0100
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [DATA_WIDTH-1:0]    op_a,
    input  logic [DATA_WIDTH-1:0]    op_b,
    output logic                     busy,
    output logic                     done,
    output logic [DATA_WIDTH-1:0]    result,
    input  logic [DATA_WIDTH-1:0]    core_srca,
    input  logic [DATA_WIDTH-1:0]    core_srcb,
    input  logic [OPCODE_LENGTH-1:0] core_op,
    output logic [DATA_WIDTH-1:0]    alu_srca,
    output logic [DATA_WIDTH-1:0]    alu_srcb,
    output logic [OPCODE_LENGTH-1:0] alu_op,
    input  logic [DATA_WIDTH-1:0]    alu_result
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_SHIFT,
        S_DONE
    } state_t;

    localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

    state_t                state;
    logic [DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0] mcand;
    logic [DATA_WIDTH-1:0] mplier;
    logic [DATA_WIDTH-1:0] mplier_nx;

    assign mplier_nx = mplier >> 1;

    // The core owns the ALU except while a multiply is stepping.
    always_comb begin
        alu_srca = core_srca;
        alu_srcb = core_srcb;
        alu_op   = core_op;
        unique case (state)
            S_ADD: begin
                alu_srca = acc;
                alu_srcb = mcand;
                alu_op   = OP_ADD;
            end
            S_SHIFT: begin
                alu_srca = mcand;
                alu_srcb = ONE;
                alu_op   = OP_SLL;
            end
            S_IDLE, S_DONE: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        mcand  <= op_a;
                        mplier <= op_b;
                        acc    <= '0;
                        if (op_b == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else if (op_b[0]) begin
                            state <= S_ADD;
                            busy  <= 1'b1;
                        end else begin
                            state <= S_SHIFT;
                            busy  <= 1'b1;
                        end
                    end
                end
                S_ADD: begin
                    acc   <= alu_result;
                    state <= S_SHIFT;
                end
                S_SHIFT: begin
                    mcand  <= alu_result;
                    mplier <= mplier_nx;
                    // Decide on the bit that becomes mplier[0] next.
                    if (mplier_nx == '0) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (mplier[1]) begin
                        state <= S_ADD;
                    end else begin
                        state <= S_SHIFT;
                    end
                end
                S_DONE: begin
                    result <= acc;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule
